// File: rtl/wave_sequencer.sv
// wave_sequencer: sample-rate controller that sequences a wave table memory.
//
// A phase accumulator advanced by a tuning word selects the table address.
// Each sample is fetched with a one-cycle read strobe. The returned word is
// registered and offered downstream over a valid/ready handshake. Waveform
// channel changes take effect only on a phase wrap, or when leaving idle.
//
// Optional feature macro: WAVE_SEQUENCER_AMP_EN
//   When defined, an amplitude_i port scales the captured sample:
//   out = (sample * (amplitude + 1)) >> Size, truncated. All-ones is unity gain.
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   enable_i       run request, level-sensitive
//   channel_req_i  requested waveform (1 = sine, 0 = triangle)
//   tuning_word_i  phase increment per output sample
//   mem_read_o     read strobe to the table memory
//   mem_channel_o  channel select to the table memory
//   mem_address_o  table address (top LogSize bits of the accumulator)
//   mem_sample_i   table data, valid one cycle after mem_read_o
//   amplitude_i    gain control (only with WAVE_SEQUENCER_AMP_EN)
//   out_sample_o   registered sample to consumer
//   out_valid_o    out_sample_o valid
//   out_ready_i    consumer accepts
//   wrap_o         one-cycle pulse on phase wrap
module wave_sequencer #(
    parameter int unsigned Size    = 12,
    parameter int unsigned LogSize = 4,
    parameter int unsigned AccW    = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               channel_req_i,
    input  logic [AccW-1:0]    tuning_word_i,
    output logic               mem_read_o,
    output logic               mem_channel_o,
    output logic [LogSize-1:0] mem_address_o,
    input  logic [Size-1:0]    mem_sample_i,
`ifdef WAVE_SEQUENCER_AMP_EN
    input  logic [Size-1:0]    amplitude_i,
`endif
    output logic [Size-1:0]    out_sample_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic               wrap_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWait,
        StOffer
    } state_e;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic            channel_q, channel_d;
    logic [Size-1:0] sample_q, sample_d;
    logic            wrap_q, wrap_d;

    // Extra top bit holds the carry that marks a phase wrap.
    logic [AccW:0]   acc_sum;
    logic [Size-1:0] capture;

    assign acc_sum = {1'b0, acc_q} + {1'b0, tuning_word_i};

`ifdef WAVE_SEQUENCER_AMP_EN
    // amplitude + 1 needs Size+1 bits; the product fits in 2*Size+1 bits.
    logic [Size:0]   amp_gain;
    logic [2*Size:0] amp_prod;
    logic            unused_amp;

    assign amp_gain   = {1'b0, amplitude_i} + (Size + 1)'(1);
    assign amp_prod   = (2 * Size + 1)'(mem_sample_i) * (2 * Size + 1)'(amp_gain);
    assign capture    = amp_prod[2*Size-1:Size];
    assign unused_amp = ^{amp_prod[2*Size], amp_prod[Size-1:0]};
`else
    assign capture = mem_sample_i;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        channel_d = channel_q;
        sample_d  = sample_q;
        wrap_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d   = StRead;
                    channel_d = channel_req_i;
                end
            end
            StRead: begin
                state_d = StWait;
            end
            StWait: begin
                // Memory data for the strobe issued in StRead is valid now.
                sample_d = capture;
                state_d  = StOffer;
            end
            StOffer: begin
                if (out_ready_i) begin
                    acc_d  = acc_sum[AccW-1:0];
                    wrap_d = acc_sum[AccW];
                    if (acc_sum[AccW]) begin
                        channel_d = channel_req_i;
                    end
                    state_d = enable_i ? StRead : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            channel_q <= 1'b0;
            sample_q  <= '0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            channel_q <= channel_d;
            sample_q  <= sample_d;
            wrap_q    <= wrap_d;
        end
    end

    // Strobe and valid decode straight from the state register, so they clear
    // asynchronously with reset and never glitch.
    assign mem_read_o    = (state_q == StRead);
    assign out_valid_o   = (state_q == StOffer);
    assign mem_channel_o = channel_q;
    assign mem_address_o = acc_q[AccW-1 -: LogSize];
    assign out_sample_o  = sample_q;
    assign wrap_o        = wrap_q;

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
Sample-rate controller that sequences main_memory for the generator. A phase accumulator, advanced by a tuning word, produces the table address and a one-cycle read strobe. The registered sample is offered downstream (DAC/serialiser) over a valid/ready handshake. Sine/triangle channel changes are applied only at a phase wrap, so the output waveform never glitches mid-period.

Parameters:
size, 12, sample width in bits (matches main_memory size)
logsize, 4, table address width (matches main_memory logsize)
acc_w, 16, phase accumulator width; must be >= logsize

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  run request; level-sensitive
channel_req  in  1  requested waveform: 1 = sine, 0 = triangle
tuning_word  in  acc_w  phase increment per output sample
mem_read  out  1  read strobe to main_memory.read
mem_channel  out  1  to main_memory.channel
mem_address  out  logsize  to main_memory.address
mem_sample  in  size  from main_memory.sample; synchronous, 1-cycle latency
out_sample  out  size  registered sample to consumer
out_valid  out  1  out_sample valid
out_ready  in  1  consumer accepts
wrap  out  1  one-cycle pulse on phase wrap

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc=0; mem_read=0; mem_address=0; mem_channel=0; out_sample=0; out_valid=0; wrap=0.
- mem_address is always acc[acc_w-1 : acc_w-logsize], driven from a register.
- FSM states: IDLE, READ, WAIT, OFFER.
- IDLE -> READ when enable=1. On this transition, mem_channel <= channel_req.
- READ: lasts exactly 1 cycle; mem_read=1. Always -> WAIT.
- WAIT: lasts 1 cycle; mem_read=0. mem_sample is valid in this state and is registered into out_sample at the end of WAIT. -> OFFER.
- OFFER: out_valid=1. While out_ready=0, out_sample and all mem_* outputs are held stable, and no mem_read is issued.
- Handshake: out_valid=1 and out_ready=1 on the same edge. At that edge:
  - out_valid <= 0;
  - acc <= acc + tuning_word, modulo 2^acc_w; tuning_word is sampled at this edge.
- Wrap: if the addition carries out, then on the same edge wrap <= 1 for one cycle and mem_channel <= channel_req. Otherwise mem_channel is unchanged.
- After a handshake: -> READ if enable=1, else -> IDLE. acc is retained in IDLE.
- Sample period: minimum 3 cycles (READ, WAIT, OFFER with out_ready=1). Latency from READ entry to out_valid=1 is 2 cycles.
- enable=0 outside IDLE: the current transaction completes through its handshake, then the FSM goes to IDLE. Offered data is never dropped.
- tuning_word=0: address is constant and the same sample repeats; wrap never pulses.
- tuning_word >= 2^(acc_w-logsize): addresses are skipped; correct modulo wrap.
- channel_req toggling mid-period has no effect until the next wrap or IDLE exit.
- Reset mid-operation: all outputs return to reset values immediately. The memory read in flight is discarded.

Optional Feature:
Macro: WAVE_SEQUENCER_AMP_EN.
- Defined: adds input port amplitude [size-1:0].
  - The WAIT-state capture becomes out_sample <= (mem_sample * (amplitude + 1)) >> size, using a 2*size+1 bit unsigned intermediate. The result is truncated, not rounded.
  - amplitude is sampled at the end of WAIT.
  - amplitude = all ones gives unity gain. Latency is unchanged.
- Undefined: no amplitude port; out_sample <= mem_sample.

Test Plan:
- Default params, tuning_word=16'h1000, out_ready=1, enable=1 from reset release -> mem_address sequence 0,1,...,15,0. mem_read pulses every 3 cycles. wrap pulses on the handshake of the address-15 sample. out_valid rises 2 cycles after each mem_read.
- tuning_word=16'h0800 -> each address appears twice (0,0,1,1,...); wrap pulses once per 32 samples.
- Backpressure: out_ready=0 for 5 cycles during OFFER -> out_valid stays 1; out_sample, mem_address and mem_channel are constant; zero mem_read pulses. After out_ready=1, the next mem_read follows 1 cycle later.
- channel_req 0->1 while mem_address=5 -> mem_channel stays 0 through address 15. It becomes 1 at the wrap edge; the first sine read is at address 0.
- enable 1->0 during WAIT, then rst=0 during a later OFFER:
  - On enable=0: the current sample is still offered and handshaken, then the FSM goes to IDLE with the acc value retained.
  - On rst=0: out_valid, mem_read and out_sample are 0 asynchronously, before the next clk edge.
- WAVE_SEQUENCER_AMP_EN defined:
  - amplitude=12'h7FF, mem_sample=12'h800 -> out_sample=12'h400.
  - amplitude=12'hFFF, mem_sample=12'hABC -> out_sample=12'hABC.
